hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the out-of-order pipeline: F→D→R→I→E→C registers (freg, dreg, rreg, ireg, ereg, creg).
- Turns per-stage resource conditions into per-register stall/flush controls, driven through the hazard_intf modport signals.
- Sequences recovery after a branch mispredict or exception raised at ROB retire.
- Recovery order: wait for the outstanding memory op, flush all stages, then hold rename while the RAT is restored.

Parameters:
- RECOVER_CYCLES, 2, cycles stallR is held after a flush while the RAT restores (legal range 1..15).
- CNT_W, 4, width of the recovery down-counter; must hold RECOVER_CYCLES.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- icache_busy  in  1  fetch cannot deliver this cycle
- dcache_busy  in  1  memory op in E outstanding
- rob_full  in  1  ROB has no room for MACHINE_WIDTH entries
- freelist_empty  in  1  not enough free pregs for rename
- iq_full  in  1  issue queue cannot accept a group
- branch_redirect  in  1  mispredict detected at retire
- exception_valid  in  1  exception detected at retire
- stallF, stallD, stallR, stallI, stallE, stallC  out  1 each  hold the register
- flushF, flushD, flushR, flushI, flushE, flushC  out  1 each  clear the register to a bubble
- redirect_ack  out  1  one-cycle pulse; pcselect loads the redirect PC
- redirect_is_exc  out  1  cause of the current/last redirect (1 = exception)
- busy  out  1  high in any state other than RUN

Behaviour:
- State register: RUN, WAIT_MEM, FLUSH, RECOVER. Also registered: cnt[CNT_W-1:0] and redirect_is_exc.
- All outputs are combinational from state and inputs.
- Reset (resetn=0 at a clk edge): state←RUN, cnt←0, redirect_is_exc←0.
  - While resetn=0: all flush*=1, all stall*=0, redirect_ack=0, busy=0.
- RUN, no redirect. Deepest condition wins. Stalling stage X inserts a bubble into X+1 via flush(X+1).
  - dcache_busy: stallF..stallE=1, flushC=1.
  - else rob_full | freelist_empty | iq_full: stallF, stallD, stallR=1, flushI=1.
  - else icache_busy: stallF=1, flushD=1.
  - else all 0.
- RUN, redirect (branch_redirect | exception_valid):
  - Latch redirect_is_exc ← exception_valid. Exception has priority when both are high.
  - If dcache_busy: next state WAIT_MEM, outputs as the dcache_busy case.
  - Else: next state FLUSH, outputs as the no-redirect case.
- WAIT_MEM:
  - stallF..stallE=1, flushC=1.
  - A new exception_valid sets redirect_is_exc←1. A new branch never clears it.
  - On dcache_busy=0: next state FLUSH.
- FLUSH (exactly 1 cycle):
  - flushF..flushC all =1, all stalls 0, redirect_ack=1.
  - cnt←RECOVER_CYCLES; next state RECOVER.
  - Redirect inputs are ignored this cycle (their producers are being flushed).
- RECOVER:
  - stallF, stallD, stallR=1, flushI=1.
  - cnt decrements each cycle; when cnt==1, next state RUN.
  - A redirect in RECOVER re-latches the cause and goes to FLUSH next cycle (counter reloaded there).
  - dcache_busy is not relevant here; E is empty after the flush.
- busy=1 in WAIT_MEM, FLUSH, RECOVER.
- redirect_ack is never high outside FLUSH and is high for exactly one cycle per recovery.
- Reset mid-operation (any state): the next cycle is RUN with no pending redirect.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds two output ports:
  - perf_stall_cycles[31:0]: increments on every cycle with stallF=1 and resetn=1.
  - perf_redirects[31:0]: increments on every redirect_ack.
  - Both are cleared by reset and wrap at 2^32.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold resetn=0 3 cycles with all inputs high → all flush*=1, stall*=0, redirect_ack=0. Release → state RUN, busy=0, outputs follow RUN rules.
- Priority: dcache_busy=1, rob_full=1, icache_busy=1 → stallF..E=1, flushC=1, flushI=0. Drop dcache_busy → stallF/D/R=1, flushI=1. Drop rob_full → stallF=1, flushD=1 only.
- Branch redirect, no memory op, RECOVER_CYCLES=2:
  - Cycle 0 branch_redirect=1 → cycle 1 FLUSH: all flush=1, redirect_ack=1, redirect_is_exc=0.
  - Cycles 2–3 RECOVER: stallR=1, busy=1.
  - Cycle 4 RUN, busy=0.
- Exception during memory op: exception_valid=1 with dcache_busy=1 for 4 cycles → WAIT_MEM for 4 cycles with stallE=1. Then FLUSH with redirect_ack=1, redirect_is_exc=1. Exactly one ack.
- Simultaneous redirects: branch_redirect=1 and exception_valid=1 in the same cycle → redirect_is_exc=1. A redirect in the first RECOVER cycle → second FLUSH pulse next cycle, then a full RECOVER_CYCLES RECOVER.
- Perf (HAZARD_PERF_EN): 10 cycles icache_busy=1 plus one branch recovery → perf_stall_cycles=10+RECOVER_CYCLES, perf_redirects=1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side condition inputs and per-register stall/flush controls for hazard_ctrl.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface hazard_ctrl_if;
    logic       icache_busy;
    logic       dcache_busy;
    logic       rob_full;
    logic       freelist_empty;
    logic       iq_full;
    logic       branch_redirect;
    logic       exception_valid;
    logic       stallF, stallD, stallR, stallI, stallE, stallC;
    logic       flushF, flushD, flushR, flushI, flushE, flushC;
    logic       redirect_ack;
    logic       redirect_is_exc;
    logic       busy;
    logic [1:0] dbg_state;

    // Level signals, no handshake: conditions are sampled every cycle and the
    // controls are valid in the same cycle; redirect_ack is a single-cycle pulse.
    modport master (
        output icache_busy, dcache_busy, rob_full, freelist_empty, iq_full,
               branch_redirect, exception_valid,
        input  stallF, stallD, stallR, stallI, stallE, stallC,
               flushF, flushD, flushR, flushI, flushE, flushC,
               redirect_ack, redirect_is_exc, busy, dbg_state
    );

    modport slave (
        input  icache_busy, dcache_busy, rob_full, freelist_empty, iq_full,
               branch_redirect, exception_valid,
        output stallF, stallD, stallR, stallI, stallE, stallC,
               flushF, flushD, flushR, flushI, flushE, flushC,
               redirect_ack, redirect_is_exc, busy, dbg_state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the F-D-R-I-E-C pipeline registers with redirect recovery.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 4
) (
    input  logic         clk,
    input  logic         resetn,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  perf_stall_cycles,
    output logic [31:0]  perf_redirects
`endif
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2,
        RECOVER  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RECOVER_CYCLES);

    // Vector bit order is F,D,R,I,E,C from MSB to LSB.
    localparam logic [5:0] ST_TO_E = 6'b111110;
    localparam logic [5:0] ST_TO_R = 6'b111000;
    localparam logic [5:0] ST_F    = 6'b100000;
    localparam logic [5:0] FL_C    = 6'b000001;
    localparam logic [5:0] FL_I    = 6'b000100;
    localparam logic [5:0] FL_D    = 6'b010000;
    localparam logic [5:0] FL_ALL  = 6'b111111;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             is_exc, is_exc_n;
    logic [5:0]       stall, flush;
    logic             ack;
    logic             redirect;

    assign redirect = hz.branch_redirect | hz.exception_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= RUN;
            cnt    <= '0;
            is_exc <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            is_exc <= is_exc_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        is_exc_n = is_exc;
        stall    = '0;
        flush    = '0;
        ack      = 1'b0;
        case (state)
            RUN: begin
                // Deepest blocked stage wins; the stage behind it gets a bubble.
                if (hz.dcache_busy) begin
                    stall = ST_TO_E;
                    flush = FL_C;
                end else if (hz.rob_full | hz.freelist_empty | hz.iq_full) begin
                    stall = ST_TO_R;
                    flush = FL_I;
                end else if (hz.icache_busy) begin
                    stall = ST_F;
                    flush = FL_D;
                end
                if (redirect) begin
                    is_exc_n = hz.exception_valid;
                    state_n  = hz.dcache_busy ? WAIT_MEM : FLUSH;
                end
            end
            WAIT_MEM: begin
                stall = ST_TO_E;
                flush = FL_C;
                if (hz.exception_valid) is_exc_n = 1'b1;
                if (!hz.dcache_busy)    state_n  = FLUSH;
            end
            FLUSH: begin
                flush   = FL_ALL;
                ack     = 1'b1;
                cnt_n   = RELOAD;
                state_n = RECOVER;
            end
            RECOVER: begin
                stall = ST_TO_R;
                flush = FL_I;
                if (redirect) begin
                    is_exc_n = hz.exception_valid;
                    state_n  = FLUSH;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
        if (!resetn) begin
            stall = '0;
            flush = FL_ALL;
            ack   = 1'b0;
        end
    end

    assign {hz.stallF, hz.stallD, hz.stallR, hz.stallI, hz.stallE, hz.stallC} = stall;
    assign {hz.flushF, hz.flushD, hz.flushR, hz.flushI, hz.flushE, hz.flushC} = flush;
    assign hz.redirect_ack    = ack;
    assign hz.redirect_is_exc = is_exc;
    assign hz.busy            = resetn & (state != RUN);
    assign hz.dbg_state       = state;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (stall[5]) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (ack)      perf_redirects    <= perf_redirects + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives inputs, queues the expected
// control vector, and compares it against the DUT on the falling edge.
module tb_hazard_ctrl;
    logic clk;
    logic resetn;

    hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
`endif

    hazard_ctrl #(.RECOVER_CYCLES(2), .CNT_W(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (hz.slave)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
`endif
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input packing: {icache, dcache, rob, freelist, iq, branch, exception}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_IC   = 7'b1000000;
    localparam logic [6:0] I_DC   = 7'b0100000;
    localparam logic [6:0] I_ROB  = 7'b0010000;
    localparam logic [6:0] I_FL   = 7'b0001000;
    localparam logic [6:0] I_IQ   = 7'b0000100;
    localparam logic [6:0] I_BR   = 7'b0000010;
    localparam logic [6:0] I_EX   = 7'b0000001;
    localparam logic [6:0] I_ALL  = 7'b1111111;

    localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_FLUSH = 2'd2, S_REC = 2'd3;

    // Expected output packing: {stall F..C, flush F..C, ack, is_exc, busy, state}
    function automatic logic [16:0] mk(input logic [5:0] s, input logic [5:0] f,
                                       input logic a, input logic e, input logic b,
                                       input logic [1:0] st);
        return {s, f, a, e, b, st};
    endfunction

    logic [16:0] exp_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_redir = 0;

    function automatic logic [16:0] observe();
        return {hz.stallF, hz.stallD, hz.stallR, hz.stallI, hz.stallE, hz.stallC,
                hz.flushF, hz.flushD, hz.flushR, hz.flushI, hz.flushE, hz.flushC,
                hz.redirect_ack, hz.redirect_is_exc, hz.busy, hz.dbg_state};
    endfunction

    // driver task: drive one cycle of inputs, queue expectation, check, advance
    task automatic step(input logic rst_n, input logic [6:0] in,
                        input logic [16:0] exp, input string tag);
        logic [16:0] obs, want;
        resetn = rst_n;
        {hz.icache_busy, hz.dcache_busy, hz.rob_full, hz.freelist_empty,
         hz.iq_full, hz.branch_redirect, hz.exception_valid} = in;
        exp_q.push_back(exp);
        @(negedge clk);
        obs  = observe();
        want = exp_q.pop_front();
        total_cnt++;
        assert (obs === want) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
        if (!rst_n) begin
            exp_stall = 0;
            exp_redir = 0;
        end else begin
            if (want[16]) exp_stall++;
            if (want[4])  exp_redir++;
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] Z = 6'b000000;

    initial begin
        resetn = 1'b0;
        {hz.icache_busy, hz.dcache_busy, hz.rob_full, hz.freelist_empty,
         hz.iq_full, hz.branch_redirect, hz.exception_valid} = I_ALL;
        @(posedge clk);
        #1;

        // Reset held with every input high
        for (int i = 0; i < 3; i++)
            step(1'b0, I_ALL, mk(Z, 6'b111111, 0, 0, 0, S_RUN), "reset");
        step(1'b1, I_NONE, mk(Z, Z, 0, 0, 0, S_RUN), "post_reset_idle");

        // Priority ladder
        step(1'b1, I_DC | I_ROB | I_IC, mk(6'b111110, 6'b000001, 0, 0, 0, S_RUN), "prio_dcache");
        step(1'b1, I_ROB | I_IC,        mk(6'b111000, 6'b000100, 0, 0, 0, S_RUN), "prio_rob");
        step(1'b1, I_IC,                mk(6'b100000, 6'b010000, 0, 0, 0, S_RUN), "prio_icache");
        step(1'b1, I_IQ,                mk(6'b111000, 6'b000100, 0, 0, 0, S_RUN), "prio_iq");
        step(1'b1, I_FL,                mk(6'b111000, 6'b000100, 0, 0, 0, S_RUN), "prio_freelist");

        // Exception while a memory op is outstanding; a branch in WAIT_MEM keeps the exception cause
        step(1'b1, I_DC | I_EX, mk(6'b111110, 6'b000001, 0, 0, 0, S_RUN), "exc_mem_run");
        for (int i = 0; i < 3; i++)
            step(1'b1, I_DC | I_EX, mk(6'b111110, 6'b000001, 0, 1, 1, S_WAIT), "exc_mem_wait");
        step(1'b1, I_BR,   mk(6'b111110, 6'b000001, 0, 1, 1, S_WAIT), "exc_mem_wait_last");
        step(1'b1, I_NONE, mk(Z, 6'b111111, 1, 1, 1, S_FLUSH),        "exc_mem_flush");
        step(1'b1, I_NONE, mk(6'b111000, 6'b000100, 0, 1, 1, S_REC),  "exc_mem_rec1");
        step(1'b1, I_NONE, mk(6'b111000, 6'b000100, 0, 1, 1, S_REC),  "exc_mem_rec2");
        step(1'b1, I_NONE, mk(Z, Z, 0, 1, 0, S_RUN),                  "exc_mem_done");

        // Branch redirect, no memory op
        step(1'b1, I_BR,   mk(Z, Z, 0, 1, 0, S_RUN),                  "br_run");
        step(1'b1, I_NONE, mk(Z, 6'b111111, 1, 0, 1, S_FLUSH),        "br_flush");
        step(1'b1, I_NONE, mk(6'b111000, 6'b000100, 0, 0, 1, S_REC),  "br_rec1");
        step(1'b1, I_NONE, mk(6'b111000, 6'b000100, 0, 0, 1, S_REC),  "br_rec2");
        step(1'b1, I_IC,   mk(6'b100000, 6'b010000, 0, 0, 0, S_RUN),  "br_done");

        // Simultaneous redirects, then a branch in the first RECOVER cycle
        step(1'b1, I_BR | I_EX, mk(Z, Z, 0, 0, 0, S_RUN),             "sim_run");
        step(1'b1, I_NONE, mk(Z, 6'b111111, 1, 1, 1, S_FLUSH),        "sim_flush");
        step(1'b1, I_BR,   mk(6'b111000, 6'b000100, 0, 1, 1, S_REC),  "sim_rec_redirect");
        step(1'b1, I_EX,   mk(Z, 6'b111111, 1, 0, 1, S_FLUSH),        "sim_flush2_ignore");
        step(1'b1, I_NONE, mk(6'b111000, 6'b000100, 0, 0, 1, S_REC),  "sim_rec1");
        step(1'b1, I_NONE, mk(6'b111000, 6'b000100, 0, 0, 1, S_REC),  "sim_rec2");
        step(1'b1, I_NONE, mk(Z, Z, 0, 0, 0, S_RUN),                  "sim_done");

        // Reset in the middle of a recovery
        step(1'b1, I_BR,   mk(Z, Z, 0, 0, 0, S_RUN),                  "mid_run");
        step(1'b1, I_NONE, mk(Z, 6'b111111, 1, 0, 1, S_FLUSH),        "mid_flush");
        step(1'b0, I_NONE, mk(Z, 6'b111111, 0, 0, 0, S_REC),          "mid_reset");
        step(1'b1, I_NONE, mk(Z, Z, 0, 0, 0, S_RUN),                  "mid_after_reset");

`ifdef HAZARD_PERF_EN
        // Ten icache stalls plus one branch recovery
        for (int i = 0; i < 10; i++)
            step(1'b1, I_IC, mk(6'b100000, 6'b010000, 0, 0, 0, S_RUN), "perf_icache");
        step(1'b1, I_BR,   mk(Z, Z, 0, 0, 0, S_RUN),                  "perf_br");
        step(1'b1, I_NONE, mk(Z, 6'b111111, 1, 0, 1, S_FLUSH),        "perf_flush");
        step(1'b1, I_NONE, mk(6'b111000, 6'b000100, 0, 0, 1, S_REC),  "perf_rec1");
        step(1'b1, I_NONE, mk(6'b111000, 6'b000100, 0, 0, 1, S_REC),  "perf_rec2");
        total_cnt++;
        assert (perf_stall_cycles === 32'(exp_stall)) pass_cnt++;
        else $error("FAIL perf_stall_cycles: observed %0d expected %0d", perf_stall_cycles, exp_stall);
        total_cnt++;
        assert (perf_redirects === 32'(exp_redir)) pass_cnt++;
        else $error("FAIL perf_redirects: observed %0d expected %0d", perf_redirects, exp_redir);
`endif

        // final report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
